// File: rtl/mc_ssram_pkg.sv
// Shared types and constants for the mc_ssram_resp SSRAM device model.
// Burst order helper covers both linear-wrap and interleaved sequences.
package mc_ssram_pkg;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 2;
    localparam int WAKE_CYC  = 2;
    localparam int WAKE_W    = 2;

    typedef struct packed {
        logic [3:0]  dp;
        logic [31:0] data;
    } ssram_word_t;

    // Low address bits of the current beat; the upper base bits never change within a burst.
    function automatic logic [CNT_W-1:0] beat_lo(input logic [CNT_W-1:0] base_lo,
                                                 input logic [CNT_W-1:0] cnt,
                                                 input logic             intlv);
        return intlv ? (base_lo ^ cnt) : (base_lo + cnt);
    endfunction

endpackage

// File: rtl/mc_ssram_rdpipe.sv
// READ_LAT-deep read data pipeline (1 or 2 stages) with a valid bit riding along.
// The output word only reloads when a read completes, so it holds between reads.
module mc_ssram_rdpipe #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        flush,
    input  logic        vld_in,
    input  logic [35:0] word_in,
    output logic [35:0] word_out,
    output logic        vld_out
);

    logic [35:0] data_p0;
    logic        vld_p0;

    // stage 0: array read captured on the issuing edge
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= vld_in & ~flush;
            if (vld_in && !flush) data_p0 <= word_in;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [35:0] data_p1;
            logic        vld_p1;

            // stage 1: extra output register for the pipelined part
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    data_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0 & ~flush;
                    if (vld_p0 && !flush) data_p1 <= data_p0;
                end
            end

            assign word_out = data_p1;
            assign vld_out  = vld_p1;
        end else begin : g_lat1
            assign word_out = data_p0;
            assign vld_out  = vld_p0;
        end
    endgenerate

endmodule

// File: rtl/mc_ssram_resp.sv
// Synthesizable SSRAM device end: burst control, sleep/wake, byte-masked array, read pipe.
// Define MC_SSRAM_INTLV_EN for interleaved burst order; default is linear wrap.
module mc_ssram_resp
    import mc_ssram_pkg::*;
#(
    parameter int AW       = 15,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        mc_cs_,
    input  logic [23:0] mc_addr,
    input  logic        mc_adsc_,
    input  logic        mc_adv_,
    input  logic        mc_we_,
    input  logic        mc_oe_,
    input  logic [3:0]  mc_dqm,
    input  logic [31:0] mc_data_i,
    input  logic [3:0]  mc_dp_i,
    input  logic        mc_zz,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_dp_o,
    output logic        mem_data_oe,
    output logic        burst_active
);

`ifdef MC_SSRAM_INTLV_EN
    localparam logic INTLV = 1'b1;
`else
    localparam logic INTLV = 1'b0;
`endif

    logic [AW-1:0]    base_q;
    logic [CNT_W-1:0] cnt_q;
    logic             burst_q;
    logic [WAKE_W-1:0] wake_q;
    logic             rdy_q;

    logic             start;
    logic             desel;
    logic             adv;
    logic             acc;
    logic [AW-1:0]    base_n;
    logic [CNT_W-1:0] cnt_n;
    logic [AW-1:0]    acc_addr;

    logic             unused_addr_hi;
    assign unused_addr_hi = ^mc_addr[23:AW];

    // rdy_q masks the first edge after reset release so nothing is accessed on it
    always_comb begin
        start = 1'b0;
        desel = 1'b0;
        adv   = 1'b0;
        if (rdy_q && !mc_zz) begin
            if (!mc_adsc_) begin
                if (wake_q == '0) begin
                    if (mc_cs_) desel = 1'b1;
                    else        start = 1'b1;
                end
            end else if (!mc_adv_ && burst_q) begin
                adv = 1'b1;
            end
        end
        acc      = start | adv;
        base_n   = start ? mc_addr[AW-1:0] : base_q;
        cnt_n    = start ? '0 : (adv ? cnt_q + 1'b1 : cnt_q);
        acc_addr = {base_n[AW-1:CNT_W], beat_lo(base_n[CNT_W-1:0], cnt_n, INTLV)};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            base_q  <= '0;
            cnt_q   <= '0;
            burst_q <= 1'b0;
            wake_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (mc_zz) begin
                burst_q <= 1'b0;
                wake_q  <= WAKE_W'(WAKE_CYC);
            end else begin
                if (wake_q != '0) wake_q <= wake_q - 1'b1;
                if (start) begin
                    burst_q <= 1'b1;
                    base_q  <= base_n;
                    cnt_q   <= cnt_n;
                end else if (desel) begin
                    burst_q <= 1'b0;
                end else if (adv) begin
                    cnt_q <= cnt_n;
                end
            end
        end
    end

    logic [35:0] mem [0:(1<<AW)-1];
    logic        wr_en;
    logic        rd_issue;
    ssram_word_t rd_word;
    ssram_word_t rd_out;
    logic        rd_vld;

    assign wr_en    = acc & ~mc_we_;
    assign rd_issue = acc & mc_we_;

    // Read-before-write on the same edge; a read one cycle later sees the new word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && !mc_dqm[i]) begin
                mem[acc_addr][8*i +: 8] <= mc_data_i[8*i +: 8];
                mem[acc_addr][32+i]     <= mc_dp_i[i];
            end
        end
    end

    assign rd_word = mem[acc_addr];

    mc_ssram_rdpipe #(
        .READ_LAT (READ_LAT)
    ) u_rdpipe (
        .clk      (clk),
        .rst_     (rst_),
        .flush    (mc_zz),
        .vld_in   (rd_issue),
        .word_in  (rd_word),
        .word_out (rd_out),
        .vld_out  (rd_vld)
    );

    assign mem_data_o   = rd_out.data;
    assign mem_dp_o     = rd_out.dp;
    assign mem_data_oe  = rd_vld & ~mc_oe_ & ~mc_zz;
    assign burst_active = burst_q;

endmodule

// File: tb/tb_mc_ssram_resp.sv
// Scoreboard bench for mc_ssram_resp: directed protocol cases plus randomized bursts
// against a word-level memory model; a negedge monitor pops expected reads.
`timescale 1ns/1ps
module tb_mc_ssram_resp;

    localparam int AW       = 15;
    localparam int READ_LAT = 2;
    localparam int LAT      = READ_LAT - 1;
    localparam int AMASK    = (1 << AW) - 1;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        mc_cs_ = 1'b1;
    logic [23:0] mc_addr = '0;
    logic        mc_adsc_ = 1'b1;
    logic        mc_adv_ = 1'b1;
    logic        mc_we_ = 1'b1;
    logic        mc_oe_ = 1'b0;
    logic [3:0]  mc_dqm = '0;
    logic [31:0] mc_data_i = '0;
    logic [3:0]  mc_dp_i = '0;
    logic        mc_zz = 1'b0;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_dp_o;
    logic        mem_data_oe;
    logic        burst_active;

    mc_ssram_resp #(.AW(AW), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst_(rst_), .mc_cs_(mc_cs_), .mc_addr(mc_addr), .mc_adsc_(mc_adsc_),
        .mc_adv_(mc_adv_), .mc_we_(mc_we_), .mc_oe_(mc_oe_), .mc_dqm(mc_dqm),
        .mc_data_i(mc_data_i), .mc_dp_i(mc_dp_i), .mc_zz(mc_zz), .mem_data_o(mem_data_o),
        .mem_dp_o(mem_dp_o), .mem_data_oe(mem_data_oe), .burst_active(burst_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic [35:0] word;
        bit          known;
    } exp_t;
    exp_t q[$];

    logic [35:0] mdl [int];
    bit m_on   = 0;
    int m_base = 0;
    int m_beat = 0;
    int m_wake = 0;
    bit m_skip = 1;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int beat_addr(input int base, input int beat);
`ifdef MC_SSRAM_INTLV_EN
        return (base & ~3) | ((base & 3) ^ beat);
`else
        return (base & ~3) | ((base + beat) & 3);
`endif
    endfunction

    // Behaviour of one clock edge, applied after the edge with the values that were sampled.
    task automatic model_edge();
        int          a;
        bit          acc;
        logic [35:0] w;
        exp_t        e;
        acc = 0;
        if (mc_zz) begin
            m_on = 0;
            m_wake = 2;
            m_skip = 0;
            return;
        end
        if (m_skip) begin
            m_skip = 0;
            return;
        end
        if (!mc_adsc_) begin
            if (m_wake == 0) begin
                if (mc_cs_) m_on = 0;
                else begin
                    m_on = 1;
                    m_base = int'(mc_addr) & AMASK;
                    m_beat = 0;
                    acc = 1;
                end
            end
        end else if (!mc_adv_ && m_on) begin
            m_beat = (m_beat + 1) % 4;
            acc = 1;
        end
        if (m_wake > 0) m_wake--;
        if (acc) begin
            a = beat_addr(m_base, m_beat);
            if (!mc_we_) begin
                if (mdl.exists(a)) begin
                    w = mdl[a];
                    for (int i = 0; i < 4; i++) begin
                        if (!mc_dqm[i]) begin
                            w[8*i +: 8] = mc_data_i[8*i +: 8];
                            w[32+i] = mc_dp_i[i];
                        end
                    end
                    mdl[a] = w;
                end else if (mc_dqm == 4'h0) begin
                    mdl[a] = {mc_dp_i, mc_data_i};
                end
            end else begin
                e.due = cyc + LAT;
                e.known = mdl.exists(a);
                e.word = e.known ? mdl[a] : 36'h0;
                q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        if (mc_zz) begin
            while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
        end
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drive(input logic cs_, input logic adsc_, input logic adv_, input logic we_,
                         input int addr, input logic [3:0] dqm, input logic [31:0] d,
                         input logic [3:0] p);
        mc_cs_ = cs_; mc_adsc_ = adsc_; mc_adv_ = adv_; mc_we_ = we_;
        mc_addr = 24'(addr); mc_dqm = dqm; mc_data_i = d; mc_dp_i = p; mc_zz = 1'b0;
    endtask

    task automatic idle();
        drive(0, 1, 1, 1, 0, 4'h0, 32'h0, 4'h0); tick();
    endtask
    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] p, input logic [3:0] m);
        drive(0, 0, 1, 0, a, m, d, p); tick();
    endtask
    task automatic rd(input int a);
        drive(0, 0, 1, 1, a, 4'h0, 32'h0, 4'h0); tick();
    endtask
    task automatic adv_rd();
        drive(0, 1, 0, 1, 0, 4'h0, 32'h0, 4'h0); tick();
    endtask
    task automatic adv_wr(input logic [31:0] d, input logic [3:0] p);
        drive(0, 1, 0, 0, 0, 4'h0, d, p); tick();
    endtask
    task automatic settle(input int k);
        while (cyc < k + LAT) idle();
    endtask

    // Monitor: every presented read must be the oldest one due on exactly this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mem_data_oe) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %h with no read due at cycle %0d", mem_data_o, cyc);
            end else begin
                e = q.pop_front();
                if (e.known) chk("rd_data", {mem_dp_o, mem_data_o}, e.word);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL rd_missing: got no output expected %h due cycle %0d", q[0].word, q[0].due);
            void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    int ord[4];
    int k;
    int groups[$];

    initial begin
`ifdef MC_SSRAM_INTLV_EN
        ord = '{1, 0, 3, 2};
`else
        ord = '{1, 2, 3, 0};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 36'(mem_data_o), 36'h0);
        chk("rst_dp", 36'(mem_dp_o), 36'h0);
        chk("rst_oe", 36'(mem_data_oe), 36'h0);
        chk("rst_burst", 36'(burst_active), 36'h0);
        @(negedge clk);
        rst_ = 1'b1;
        idle();

        // Fill the regions used below with full-word write bursts.
        for (int g = 0; g < 64; g += 4) groups.push_back(g);
        groups.push_back(32'h40);
        groups.push_back(32'h80);
        foreach (groups[gi]) begin
            wr(groups[gi], $urandom, 4'($urandom), 4'h0);
            for (int j = 1; j < 4; j++) adv_wr($urandom, 4'($urandom));
        end
        wr(32'h100, 32'hB000_0000, 4'h0, 4'h0);
        for (int j = 1; j < 4; j++) adv_wr(32'hB000_0000 | j, 4'(j));

        // Single write then read, plus async OE.
        wr(32'h10, 32'hDEAD_BEEF, 4'hA, 4'h0);
        rd(32'h10); k = cyc; settle(k);
        chk("wr_rd_data", 36'(mem_data_o), 36'hDEAD_BEEF);
        chk("wr_rd_dp", 36'(mem_dp_o), 36'hA);
        chk("wr_rd_oe", 36'(mem_data_oe), 36'h1);
        mc_oe_ = 1'b1; #1;
        chk("oe_high", 36'(mem_data_oe), 36'h0);
        mc_oe_ = 1'b0; #1;
        chk("oe_low", 36'(mem_data_oe), 36'h1);

        // Byte mask.
        wr(32'h20, 32'h1122_3344, 4'h0, 4'h0);
        wr(32'h20, 32'hAABB_CCDD, 4'hF, 4'b0101);
        chk("hold_data", 36'(mem_data_o), 36'hDEAD_BEEF);
        chk("hold_oe", 36'(mem_data_oe), 36'h0);
        rd(32'h20); k = cyc; settle(k);
        chk("mask_data", 36'(mem_data_o), 36'hAA22_CC44);
        chk("mask_dp", 36'(mem_dp_o), 36'hA);

        // Four-beat read burst from 0x101, one beat per clock.
        for (int j = 0; j < 4 + LAT; j++) begin
            if (j == 0) rd(32'h101);
            else if (j < 4) adv_rd();
            else idle();
            if (j >= LAT) begin
                chk("burst_data", 36'(mem_data_o), 36'hB000_0000 | 36'(ord[j-LAT]));
                chk("burst_dp", 36'(mem_dp_o), 36'(ord[j-LAT]));
                chk("burst_oe", 36'(mem_data_oe), 36'h1);
            end
        end
        chk("burst_open", 36'(burst_active), 36'h1);

        // ADSC beats ADV; the older burst's reads still complete.
        rd(32'h40); adv_rd();
        drive(0, 0, 0, 1, 32'h80, 4'h0, 32'h0, 4'h0); tick();
        adv_rd();
        repeat (LAT + 1) idle();

        // Deselect.
        drive(1, 0, 1, 0, 32'h10, 4'h0, 32'h0BAD_F00D, 4'h5); tick();
        chk("desel_burst", 36'(burst_active), 36'h0);
        rd(32'h10); k = cyc; settle(k);
        chk("desel_nowr", 36'(mem_data_o), 36'hDEAD_BEEF);

        // Sleep mid-burst, then wake blocking.
        rd(32'h0); adv_rd(); adv_rd();
        chk("pre_zz_oe", 36'(mem_data_oe), 36'h1);
        drive(0, 1, 1, 1, 0, 4'h0, 32'h0, 4'h0); mc_zz = 1'b1; #1;
        chk("zz_oe", 36'(mem_data_oe), 36'h0);
        tick();
        mc_zz = 1'b1; tick();
        chk("zz_burst", 36'(burst_active), 36'h0);
        idle();
        wr(32'h30, 32'h3030_3030, 4'h3, 4'h0);
        chk("wake_drop", 36'(burst_active), 36'h0);
        wr(32'h31, 32'h3131_3131, 4'h1, 4'h0);
        chk("wake_accept", 36'(burst_active), 36'h1);
        rd(32'h31); k = cyc; settle(k);
        chk("wake_wr", 36'(mem_data_o), 36'h3131_3131);
        rd(32'h30); k = cyc; settle(k);
        checks++;
        if (mem_data_o === 32'h3030_3030) begin
            errors++;
            $display("FAIL wake_drop_wr: got %h expected old contents", mem_data_o);
        end

        // Asynchronous reset during a read burst.
        rd(32'h100); adv_rd();
        #2;
        rst_ = 1'b0;
        while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
        m_on = 0; m_wake = 0; m_skip = 1;
        #1;
        chk("arst_oe", 36'(mem_data_oe), 36'h0);
        chk("arst_burst", 36'(burst_active), 36'h0);
        chk("arst_data", 36'(mem_data_o), 36'h0);
        @(posedge clk); @(posedge clk);
        #2;
        rst_ = 1'b1;
        wr(32'h10, 32'hFFFF_FFFF, 4'hF, 4'h0);
        rd(32'h10); k = cyc; settle(k);
        chk("release_nowr", 36'(mem_data_o), 36'hDEAD_BEEF);
        rd(32'h101); k = cyc; settle(k);
        chk("retain_data", {mem_dp_o, mem_data_o}, {4'h1, 32'hB000_0001});

        // Randomized traffic over the filled low region.
        for (int n = 0; n < 300; n++) begin
            int          r;
            int          a;
            logic        we;
            logic [3:0]  m;
            logic [31:0] d;
            logic [3:0]  p;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 63) | ($urandom_range(0, 511) << AW);
            we = 1'($urandom_range(0, 1));
            m = 4'($urandom); d = $urandom; p = 4'($urandom);
            if (r < 4)       drive(1'($urandom_range(0, 7) == 0), 0, 1, we, a, m, d, p);
            else if (r < 8)  drive(0, 1, 0, we, a, m, d, p);
            else if (r == 8) drive(0, 0, 0, we, a, m, d, p);
            else             drive(0, 1, 1, 1, a, m, d, p);
            tick();
        end
        repeat (LAT + 2) idle();
        chk("drain", 36'(q.size()), 36'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
